// File: rtl/hack_seq_ctrl_if.sv
// Instruction-memory fetch interface for the Hack sequencer.
//
// Purpose: bundles the req/ack fetch handshake between the sequencer (master)
// and the instruction memory (slave).
//
// Signals:
//   req   - fetch request, held high by the master until acknowledged
//   addr  - fetch address (PC_W bits), stable while req is high
//   ack   - fetch complete; rdata valid in the same cycle (may be combinational)
//   rdata - fetched instruction (INSTR_W bits)
interface hack_seq_ctrl_if #(
    parameter int unsigned PC_W    = 15,
    parameter int unsigned INSTR_W = 16
);
    logic               req;
    logic [PC_W-1:0]    addr;
    logic               ack;
    logic [INSTR_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/hack_seq_ctrl.sv
// Multi-cycle instruction sequencer for the Hack CPU.
//
// Purpose: fetches each instruction over the imem req/ack handshake, latches it,
// strobes the datapath for one commit cycle, then updates the PC (sequential or
// jump to A). A taken jump to the current PC parks the CPU in HALT when
// HALT_DETECT is set.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   run      - sequencing enable, sampled in IDLE and at the end of EXEC
//   imem     - fetch interface (master): req, addr, ack, rdata
//   instr    - latched current instruction
//   exec_en  - one-cycle datapath commit strobe
//   jumpctrl - jump-condition result for instr, valid during EXEC
//   a_reg    - A-register value (jump target), valid during EXEC
//   pc       - program counter
//   halted   - high while in HALT
module hack_seq_ctrl #(
    parameter int unsigned PC_W        = 15,
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned HALT_DETECT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    hack_seq_ctrl_if.master     imem,
    output logic [INSTR_W-1:0]  instr,
    output logic                exec_en,
    input  logic                jumpctrl,
    input  logic [PC_W-1:0]     a_reg,
    output logic [PC_W-1:0]     pc,
    output logic                halted
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;

    logic                is_c_instr;
    logic                jump_taken;
    logic                halt_hit;

    // An A-instruction never jumps, whatever jumpctrl says.
    assign is_c_instr = instr_q[INSTR_W-1];
    assign jump_taken = is_c_instr && jumpctrl;
    // A taken jump onto itself can never make progress, so treat it as a halt.
    assign halt_hit   = (HALT_DETECT != 0) && jump_taken && (a_reg == pc_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                // run is not sampled here: a started fetch always completes.
                if (imem.ack) state_d = StExec;
            end
            StExec: begin
                if (halt_hit) begin
                    state_d = StHalt;
                end else if (run) begin
                    state_d = StFetch;
                end else begin
                    state_d = StIdle;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are pure decodes of the registered state.
    always_comb begin
        imem.req  = (state_q == StFetch);
        imem.addr = pc_q;
        exec_en   = (state_q == StExec);
        halted    = (state_q == StHalt);
        instr     = instr_q;
        pc        = pc_q;
    end

    // PC and instruction register next-state
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (state_q == StFetch && imem.ack) begin
            instr_d = imem.rdata;
        end
        if (state_q == StExec && !halt_hit) begin
            if (jump_taken) begin
                pc_d = a_reg;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_hack_seq_ctrl.sv
// Self-checking bench for hack_seq_ctrl: a ROM model with programmable wait
// states drives the fetch interface, per-address tables supply jumpctrl/a_reg,
// and a scoreboard checks every fetch address and every executed instruction.
module tb_hack_seq_ctrl;
    localparam int unsigned PC_W    = 15;
    localparam int unsigned INSTR_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    logic run  = 1'b0;

    logic [INSTR_W-1:0] instr, instr2;
    logic               exec_en, exec_en2, halted, halted2;
    logic               jumpctrl, jumpctrl2;
    logic [PC_W-1:0]    pc, pc2, a_reg, a_reg2;

    hack_seq_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem ();
    hack_seq_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem2 ();

    hack_seq_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .HALT_DETECT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .imem     (imem),
        .instr    (instr),
        .exec_en  (exec_en),
        .jumpctrl (jumpctrl),
        .a_reg    (a_reg),
        .pc       (pc),
        .halted   (halted)
    );

    // Second instance without halt detection, only released for the halt test.
    hack_seq_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .HALT_DETECT(0)) dut2 (
        .clk      (clk),
        .rst      (rst2),
        .run      (run),
        .imem     (imem2),
        .instr    (instr2),
        .exec_en  (exec_en2),
        .jumpctrl (jumpctrl2),
        .a_reg    (a_reg2),
        .pc       (pc2),
        .halted   (halted2)
    );

    // Memory and jump-condition models
    logic [INSTR_W-1:0] rom     [0:32767];
    bit                 jc_tab  [0:32767];
    logic [PC_W-1:0]    tgt_tab [0:32767];
    int                 mem_wait  = 0;
    int                 wait_cnt  = 0;
    logic               ack_force = 1'b0;

    assign imem.ack    = (imem.req && wait_cnt == mem_wait) || ack_force;
    assign imem.rdata  = rom[imem.addr];
    assign imem2.ack   = imem2.req;
    assign imem2.rdata = rom[imem2.addr];
    assign jumpctrl    = jc_tab[pc];
    assign a_reg       = tgt_tab[pc];
    assign jumpctrl2   = jc_tab[pc2];
    assign a_reg2      = tgt_tab[pc2];

    always @(posedge clk) begin
        if (imem.req && !imem.ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard
    logic [PC_W-1:0]    exp_addr  [$];
    logic [INSTR_W-1:0] exp_instr [$];
    logic               req_prev = 1'b0;

    always @(negedge clk) begin
        if (imem.req && !req_prev) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_addr: unexpected fetch at 0x%0h, expected none", imem.addr);
            end else begin
                chk("fetch_addr", 32'(imem.addr), 32'(exp_addr.pop_front()));
            end
        end
        if (exec_en) begin
            if (exp_instr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL exec_instr: unexpected exec of 0x%0h, expected none", instr);
            end else begin
                chk("exec_instr", 32'(instr), 32'(exp_instr.pop_front()));
            end
        end
        req_prev <= imem.req;
    end

    task automatic wait_exec_at(input logic [PC_W-1:0] a, input string name);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (exec_en && pc == a) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for exec at 0x%0h, got pc 0x%0h", name, a, pc);
    endtask

    task automatic wait_fetch_at(input logic [PC_W-1:0] a, input string name);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (imem.req && imem.addr == a) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for fetch at 0x%0h, got addr 0x%0h", name, a, imem.addr);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_pc"}, 32'(pc), 32'h0);
        chk({name, "_instr"}, 32'(instr), 32'h0);
        chk({name, "_req"}, 32'(imem.req), 32'h0);
        chk({name, "_exec"}, 32'(exec_en), 32'h0);
        chk({name, "_halted"}, 32'(halted), 32'h0);
    endtask

    initial begin
        int t [4];
        int nreq, nexec;
        bit addr_ok, idle_ok, halt_ok, seen;

        for (int i = 0; i < 32768; i++) begin
            rom[i]     = '0;
            jc_tab[i]  = 1'b0;
            tgt_tab[i] = '0;
        end
        rom[0] = 16'h0005; rom[1] = 16'h0006; rom[2] = 16'h0007; rom[3] = 16'h0008;
        rom[4]      = 16'hE307; jc_tab[4]      = 1'b1; tgt_tab[4]      = 15'h0010;
        rom['h10]   = 16'hE307; jc_tab['h10]   = 1'b0; tgt_tab['h10]   = 15'h0055;
        rom['h11]   = 16'h0010; jc_tab['h11]   = 1'b1; tgt_tab['h11]   = 15'h0030;
        rom['h12]   = 16'h0042;
        rom['h13]   = 16'hE307; jc_tab['h13]   = 1'b1; tgt_tab['h13]   = 15'h7FFF;
        rom['h7FFF] = 16'h0001; jc_tab['h7FFF] = 1'b1; tgt_tab['h7FFF] = 15'h0044;

        exp_addr  = '{15'h0, 15'h1, 15'h2, 15'h3, 15'h4, 15'h10, 15'h11, 15'h12};
        exp_instr = '{16'h0005, 16'h0006, 16'h0007, 16'h0008,
                      16'hE307, 16'hE307, 16'h0010, 16'h0042};

        // Reset with run high
        rst = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_reset_vals("in_reset");
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(imem.req), 32'h1);
        chk("first_addr", 32'(imem.addr), 32'h0);

        // Zero-wait A-instructions: one exec every 2 cycles
        for (int k = 0; k < 4; k++) begin
            wait_exec_at(PC_W'(k), "exec_seq");
            t[k] = cycle;
        end
        for (int k = 1; k < 4; k++) chk("exec_spacing", 32'(t[k] - t[k-1]), 32'd2);

        // Fetch with 3 wait states, run dropped during the wait
        wait_exec_at(15'h11, "exec_a_jc");
        mem_wait = 3;
        nreq     = 0;
        nexec    = 0;
        addr_ok  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem.req) begin
                nreq++;
                if (imem.addr != 15'h12) addr_ok = 1'b0;
            end
            if (i == 1) run = 1'b0;
            if (exec_en) begin
                nexec++;
                break;
            end
        end
        chk("wait_req_cycles", 32'(nreq), 32'd4);
        chk("wait_addr_stable", 32'(addr_ok), 32'h1);
        chk("wait_exec_count", 32'(nexec), 32'd1);
        idle_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (imem.req || exec_en) idle_ok = 1'b0;
        end
        chk("idle_after_run_drop", 32'(idle_ok), 32'h1);
        chk("idle_pc", 32'(pc), 32'h13);

        // Jump to 0x7FFF, then an A-instruction wraps the PC to 0
        mem_wait = 0;
        exp_addr.push_back(15'h13);
        exp_addr.push_back(15'h7FFF);
        exp_addr.push_back(15'h0);
        exp_instr.push_back(16'hE307);
        exp_instr.push_back(16'h0001);
        run = 1'b1;
        wait_fetch_at(15'h0, "wrap");
        chk("wrap_pc", 32'(pc), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("after_wrap_rst");

        // Self-jump halt, compared against an instance without halt detection
        rom[0]       = 16'hE307; jc_tab[0]    = 1'b1; tgt_tab[0]    = 15'h0020;
        rom['h20]    = 16'hE307; jc_tab['h20] = 1'b1; tgt_tab['h20] = 15'h0020;
        exp_addr.push_back(15'h0);
        exp_addr.push_back(15'h20);
        exp_instr.push_back(16'hE307);
        exp_instr.push_back(16'hE307);
        rst  = 1'b0;
        rst2 = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (halted) begin
                seen = 1'b1;
                break;
            end
        end
        chk("halt_reached", 32'(seen), 32'h1);
        chk("halt_pc", 32'(pc), 32'h20);
        chk("halt_req", 32'(imem.req), 32'h0);
        chk("nohalt_halted", 32'(halted2), 32'h0);
        chk("nohalt_refetch_req", 32'(imem2.req), 32'h1);
        chk("nohalt_refetch_addr", 32'(imem2.addr), 32'h20);
        halt_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem.req || exec_en || !halted || pc != 15'h20) halt_ok = 1'b0;
        end
        chk("halt_parked", 32'(halt_ok), 32'h1);
        rst  = 1'b1;
        rst2 = 1'b1;
        run  = 1'b0;
        @(negedge clk);
        chk_reset_vals("halt_cleared");

        // Reset while a fetch is waiting for ack
        exp_addr.push_back(15'h0);
        mem_wait = 3;
        rst      = 1'b0;
        run      = 1'b1;
        wait_fetch_at(15'h0, "fetch_pending");
        @(negedge clk);
        chk("pending_req", 32'(imem.req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_mid_fetch");

        // Ack arriving outside FETCH is ignored
        run       = 1'b0;
        rst       = 1'b0;
        ack_force = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stray_ack_instr", 32'(instr), 32'h0);
            chk("stray_ack_exec", 32'(exec_en), 32'h0);
        end
        ack_force = 1'b0;

        // Reset during the EXEC cycle cancels the PC update
        mem_wait = 0;
        exp_addr.push_back(15'h0);
        exp_instr.push_back(16'hE307);
        run = 1'b1;
        wait_exec_at(15'h0, "exec_before_rst");
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_mid_exec");

        rst = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_addr_drained", 32'(exp_addr.size()), 32'h0);
        chk("sb_instr_drained", 32'(exp_instr.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors %0d", errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hack_seq_ctrl.md
Name: hack_seq_ctrl

Overview:
Multi-cycle sequencer for the Hack CPU.
- Fetches each instruction from instruction memory over a req/ack handshake and latches it.
- Strobes the datapath to commit the instruction, then updates the PC.
- Takes the jump decision from the CPU jump-condition logic and loads the A-register target when a jump is taken.
- Detects a self-jump halt loop and parks the CPU.

Parameters:
PC_W, 15, width of the PC and the instruction address
INSTR_W, 16, instruction width; bit INSTR_W-1 set means C-instruction
HALT_DETECT, 1, 1 = a taken jump to the current PC enters HALT; 0 = it is executed as a normal jump

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
run  input  1  enable instruction sequencing; sampled in IDLE and at the end of EXEC
imem_req  output  1  fetch request; held high until acknowledged
imem_addr  output  PC_W  fetch address; equals pc whenever imem_req=1
imem_ack  input  1  fetch complete; imem_rdata valid in the same cycle; may be combinational from imem_req
imem_rdata  input  INSTR_W  fetched instruction
instr  output  INSTR_W  latched current instruction, driven to the datapath decode
exec_en  output  1  one-cycle commit strobe for datapath registers (A, D, M write)
jumpctrl  input  1  jump-condition result for instr, from the jump logic, valid during EXEC
a_reg  input  PC_W  A-register value (jump target), valid during EXEC
pc  output  PC_W  program counter
halted  output  1  high in HALT state

Behaviour:
- Reset is synchronous: on rst=1 at a clock edge the next state is IDLE. Reset values: pc=0, instr=0, imem_req=0, exec_en=0, halted=0. rst has priority over every other event, including mid-FETCH and mid-EXEC; an outstanding fetch is abandoned.
- State encoding and transitions:
  - IDLE: imem_req=0. If run=1, go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, instr<=imem_rdata and go to EXEC. Without ack, stay in FETCH with imem_req held high and pc/address stable.
  - EXEC: exec_en=1 for exactly this cycle. All PC updates happen at the end of EXEC:
    - C-instruction (instr[INSTR_W-1]=1) with jumpctrl=1: pc<=a_reg.
    - Otherwise: pc<=pc+1. An A-instruction ignores jumpctrl.
    - Next state is FETCH if run=1, else IDLE.
  - HALT: entered from EXEC when HALT_DETECT=1, the instruction is a C-instruction, jumpctrl=1 and a_reg==pc.
    - pc is left unchanged and halted=1 from the next cycle.
    - exec_en still pulses in that EXEC cycle.
    - HALT is exited only by rst. imem_req=0 while in HALT.
- imem_req and exec_en are registered state decodes, never combinational from inputs.
- Deasserting run mid-FETCH does not abort the fetch: the handshake completes and EXEC still executes, then the FSM goes to IDLE.
- imem_ack outside FETCH is ignored.
- Arithmetic: pc+1 is modulo 2^PC_W; 0x7FFF+1 = 0x0000 with no flag. a_reg is loaded unmodified.
- Throughput: with ack in the same cycle as req, 2 cycles per instruction (FETCH, EXEC). Each fetch wait state adds 1 cycle.
- The PC is observable on imem_addr in the FETCH cycle following EXEC.

Test Plan:
1. Reset behaviour: assert rst for 2 cycles with run=1, then release. Required: pc=0, imem_req=0, exec_en=0, halted=0 during reset; imem_req=1 with imem_addr=0 one cycle after release.
2. Sequential A-instructions: zero-wait ack, ROM[0..3]=0x0005,0x0006,0x0007,0x0008. Required: exec_en pulses every 2nd cycle; instr follows that sequence; pc=1,2,3,4.
3. Jump taken and not taken: instr=0xE307 (C, JMP bits) at pc=4.
   - jumpctrl=1, a_reg=0x0010 -> next fetch address 0x0010.
   - jumpctrl=0 -> next fetch address 5.
   - A-instr 0x0010 with jumpctrl forced 1 -> pc=5.
4. Fetch wait states and run drop: ack delayed 3 cycles and run dropped during the wait. Required: imem_req stays high with a stable address for 4 cycles; one exec_en pulse; the FSM then returns to IDLE with imem_req=0.
5. Halt and wrap:
   - pc=0x0020, C-instr jumpctrl=1, a_reg=0x0020 -> halted=1 and pc stays 0x0020 with no further req; rst clears halted.
   - With HALT_DETECT=0, the same stimulus refetches 0x0020 instead.
   - pc=0x7FFF, A-instr -> pc=0x0000.
6. Reset mid-operation: assert rst while in FETCH with ack pending, and again during the EXEC cycle. Required: next cycle is IDLE with all outputs at reset values; the late ack is ignored; pc=0.
